// File: rtl/align_add_floating_point32.sv
`timescale 1ns/1ps
// align_add_floating_point32
//
// Front end of the FP32 adder/subtractor. Unpacks two IEEE-754 single operands and orders
// them by magnitude. It then aligns the smaller mantissa to the larger exponent and adds or
// subtracts the two. The result {sign, larger_exponent, mantise_temp} feeds the FP32
// normaliser.
//
// Pipeline: three register stages, valid-qualified, no backpressure. A new operand pair is
// accepted every cycle. Data registers load only when their stage is valid. Valids shift
// every cycle.
//   S1 unpack, effective sign of B, magnitude ordering, exponent difference
//   S2 right-shift of the smaller mantissa (optional sticky collection)
//   S3 add / subtract, special and cancellation handling
//
// Parameters
//   EXT_BITS      extension bits below the fraction; mantise_temp is 25+EXT_BITS wide
//   FLUSH_DENORM  1: an operand with exponent 0 is an exact zero
//
// Build option
//   FP_ALIGN_STICKY_EN  when defined, every bit shifted out of the smaller mantissa is ORed
//                       into bit 0 of the aligned mantissa. Otherwise those bits are dropped.
//
// Ports
//   clk              clock, rising edge
//   rstn             asynchronous active-low reset
//   valid_in         in_a / in_b / sub valid this cycle
//   sub              1: a-b, 0: a+b
//   in_a, in_b       FP32 operands
//   valid_out        one pulse per accepted input, 3 clk later
//   sign             result sign
//   larger_exponent  biased exponent of the larger operand, 0xFF if either is inf/NaN
//   mantise_temp     [MW-1] carry, [MW-2] hidden one, [MW-3:EXT_BITS] fraction,
//                    [EXT_BITS-1:0] alignment extension bits
module align_add_floating_point32 #(
  parameter int unsigned EXT_BITS     = 24,
  parameter bit          FLUSH_DENORM = 1'b1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic                  sub,
  input  logic [31:0]           in_a,
  input  logic [31:0]           in_b,
  output logic                  valid_out,
  output logic                  sign,
  output logic [7:0]            larger_exponent,
  output logic [EXT_BITS+24:0]  mantise_temp
);

  localparam int unsigned MW = 25 + EXT_BITS;
  // Width of an unpacked mantissa: hidden bit, 23 fraction bits, extension bits.
  localparam int unsigned NW = MW - 1;

  // ---------------------------------------------------------------------------------------
  // S1: unpack and order by magnitude
  // ---------------------------------------------------------------------------------------
  logic          sign_a, sign_b;
  logic [7:0]    exp_a, exp_b;
  logic [22:0]   frac_a, frac_b;
  logic [NW-1:0] man_a, man_b;
  logic          a_larger;
  logic          sign_l, sign_s;
  logic [7:0]    exp_l, exp_s;
  logic [NW-1:0] man_l, man_s;

  always_comb begin
    sign_a = in_a[31];
    // Subtraction is an addition with B's sign flipped.
    sign_b = sub ? ~in_b[31] : in_b[31];
    exp_a  = in_a[30:23];
    exp_b  = in_b[30:23];
    frac_a = (FLUSH_DENORM && (exp_a == 8'd0)) ? 23'd0 : in_a[22:0];
    frac_b = (FLUSH_DENORM && (exp_b == 8'd0)) ? 23'd0 : in_b[22:0];
    man_a  = {(exp_a != 8'd0), frac_a, {EXT_BITS{1'b0}}};
    man_b  = {(exp_b != 8'd0), frac_b, {EXT_BITS{1'b0}}};
    // Ties keep A as the larger operand.
    a_larger = {exp_a, frac_a} >= {exp_b, frac_b};
    if (a_larger) begin
      sign_l = sign_a;
      sign_s = sign_b;
      exp_l  = exp_a;
      exp_s  = exp_b;
      man_l  = man_a;
      man_s  = man_b;
    end else begin
      sign_l = sign_b;
      sign_s = sign_a;
      exp_l  = exp_b;
      exp_s  = exp_a;
      man_l  = man_b;
      man_s  = man_a;
    end
  end

  logic          v1_q;
  logic          sign_l1_q, eff_sub1_q, special1_q;
  logic [7:0]    exp_l1_q, shift1_q;
  logic [NW-1:0] man_l1_q, man_s1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q       <= 1'b0;
      sign_l1_q  <= 1'b0;
      eff_sub1_q <= 1'b0;
      special1_q <= 1'b0;
      exp_l1_q   <= 8'd0;
      shift1_q   <= 8'd0;
      man_l1_q   <= '0;
      man_s1_q   <= '0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        sign_l1_q  <= sign_l;
        eff_sub1_q <= sign_l ^ sign_s;
        special1_q <= (exp_a == 8'hFF) | (exp_b == 8'hFF);
        exp_l1_q   <= exp_l;
        shift1_q   <= exp_l - exp_s;
        man_l1_q   <= man_l;
        man_s1_q   <= man_s;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // S2: align the smaller mantissa
  // ---------------------------------------------------------------------------------------
  logic          big_shift;
  logic [NW-1:0] man_s_shr, man_s_aligned;

`ifdef FP_ALIGN_STICKY_EN
  logic [NW-1:0] lost_mask;
  logic          lost_any;
`endif

  always_comb begin
    // Any shift of NW or more pushes the whole mantissa out.
    big_shift = {24'd0, shift1_q} >= 32'(NW);
    man_s_shr = big_shift ? '0 : (man_s1_q >> shift1_q);
`ifdef FP_ALIGN_STICKY_EN
    lost_mask     = big_shift ? '1 : ~({NW{1'b1}} << shift1_q);
    lost_any      = |(man_s1_q & lost_mask);
    man_s_aligned = {man_s_shr[NW-1:1], man_s_shr[0] | lost_any};
`else
    man_s_aligned = man_s_shr;
`endif
  end

  logic          v2_q;
  logic          sign_l2_q, eff_sub2_q, special2_q;
  logic [7:0]    exp_l2_q;
  logic [NW-1:0] man_l2_q, man_s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q       <= 1'b0;
      sign_l2_q  <= 1'b0;
      eff_sub2_q <= 1'b0;
      special2_q <= 1'b0;
      exp_l2_q   <= 8'd0;
      man_l2_q   <= '0;
      man_s2_q   <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        sign_l2_q  <= sign_l1_q;
        eff_sub2_q <= eff_sub1_q;
        special2_q <= special1_q;
        exp_l2_q   <= exp_l1_q;
        man_l2_q   <= man_l1_q;
        man_s2_q   <= man_s_aligned;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // S3: add / subtract
  // ---------------------------------------------------------------------------------------
  logic [MW-1:0] sum;
  logic          cancel;
  logic          sign_d;
  logic [7:0]    exp_d;

  always_comb begin
    // Ordering guarantees man_l >= man_s, so the difference never wraps.
    sum    = eff_sub2_q ? ({1'b0, man_l2_q} - {1'b0, man_s2_q})
                        : ({1'b0, man_l2_q} + {1'b0, man_s2_q});
    // Exact cancellation yields +0. The sign of an inf/NaN result always follows the
    // larger operand.
    cancel = eff_sub2_q && (sum == '0) && !special2_q;
    sign_d = cancel ? 1'b0 : sign_l2_q;
    exp_d  = special2_q ? 8'hFF : exp_l2_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out       <= 1'b0;
      sign            <= 1'b0;
      larger_exponent <= 8'd0;
      mantise_temp    <= '0;
    end else begin
      valid_out <= v2_q;
      if (v2_q) begin
        sign            <= sign_d;
        larger_exponent <= exp_d;
        mantise_temp    <= sum;
      end
    end
  end

endmodule

// File: tb/tb_align_add_floating_point32.sv
`timescale 1ns/1ps
module tb_align_add_floating_point32;

  localparam int unsigned MW = 49;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_in = 1'b0;
  logic          sub = 1'b0;
  logic [31:0]   in_a = 32'd0;
  logic [31:0]   in_b = 32'd0;
  logic          valid_out;
  logic          sign;
  logic [7:0]    larger_exponent;
  logic [MW-1:0] mantise_temp;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  align_add_floating_point32 dut (
    .clk             (clk),
    .rstn            (rstn),
    .valid_in        (valid_in),
    .sub             (sub),
    .in_a            (in_a),
    .in_b            (in_b),
    .valid_out       (valid_out),
    .sign            (sign),
    .larger_exponent (larger_exponent),
    .mantise_temp    (mantise_temp)
  );

  typedef struct packed {
    logic          sgn;
    logic [7:0]    expo;
    logic [MW-1:0] mant;
  } res_t;

  typedef struct {
    bit   v;
    res_t r;
  } pend_t;

  // Reference: real-valued view of the operation, with mantissas held as integers scaled
  // by 2^47 (1.0 -> 2^47). Denormals are flushed to zero.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic s);
    res_t            r;
    bit              sa, sb, sl, ss, eff, special, lost;
    int unsigned     ea, eb, el, es, d;
    longint unsigned fa, fb, ma, mb, ml, msm, al, res;
    sa = a[31];
    sb = b[31] ^ s;
    ea = a[30:23];
    eb = b[30:23];
    fa = (ea == 0) ? 64'd0 : 64'(a[22:0]);
    fb = (eb == 0) ? 64'd0 : 64'(b[22:0]);
    ma = (ea == 0) ? 64'd0 : (fa + 64'd8388608) * 64'd16777216;
    mb = (eb == 0) ? 64'd0 : (fb + 64'd8388608) * 64'd16777216;
    if ((ea > eb) || ((ea == eb) && (fa >= fb))) begin
      sl = sa; ss = sb; el = ea; es = eb; ml = ma; msm = mb;
    end else begin
      sl = sb; ss = sa; el = eb; es = ea; ml = mb; msm = ma;
    end
    d = el - es;
    if (d >= 48) begin
      al   = 64'd0;
      lost = (msm != 64'd0);
    end else begin
      al   = msm >> d;
      lost = ((al << d) != msm);
    end
`ifdef FP_ALIGN_STICKY_EN
    if (lost) al = al | 64'd1;
`else
    lost = 1'b0;
`endif
    eff     = (sl != ss);
    res     = eff ? (ml - al) : (ml + al);
    special = (ea == 255) || (eb == 255);
    r.mant  = res[MW-1:0];
    r.expo  = special ? 8'hFF : el[7:0];
    if (special)                     r.sgn = sl;
    else if (ma == 0 && mb == 0)     r.sgn = sa & sb;
    else if (eff && res == 64'd0)    r.sgn = 1'b0;
    else                             r.sgn = sl;
    return r;
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] v;
    int          e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: v = {v[31], other[30:0]};
      3, 4, 5: begin
        e = int'(other[30:23]) + int'($urandom_range(0, 8)) - 4;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = e[7:0];
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid_out: got %0b want 0", valid_out);
    end
    checks++;
    if (sign !== 1'b0) begin
      errors++; $display("FAIL reset_sign: got %0b want 0", sign);
    end
    checks++;
    if (larger_exponent !== 8'h00) begin
      errors++; $display("FAIL reset_exp: got %h want 00", larger_exponent);
    end
    checks++;
    if (mantise_temp !== '0) begin
      errors++; $display("FAIL reset_mant: got %h want 0", mantise_temp);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid: got %0b want 0", valid_out);
    end
  endtask

  task automatic test_directed();
    logic [31:0]   va [9];
    logic [31:0]   vb [9];
    logic          vs [9];
    logic          xs [9];
    logic [7:0]    xe [9];
    logic [MW-1:0] xm [9];
    bit            cm [9];
    va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vs[0] = 0; xs[0] = 0; xe[0] = 8'h7F;
    xm[0] = 49'h1_0000_0000_0000; cm[0] = 1;
    va[1] = 32'h3F800000; vb[1] = 32'h3F800000; vs[1] = 1; xs[1] = 0; xe[1] = 8'h7F;
    xm[1] = 49'h0; cm[1] = 1;
    va[2] = 32'hC0400000; vb[2] = 32'h3F800000; vs[2] = 0; xs[2] = 1; xe[2] = 8'h80;
    xm[2] = 49'h0_8000_0000_0000; cm[2] = 1;
    va[3] = 32'h3F800000; vb[3] = 32'h21800000; vs[3] = 0; xs[3] = 0; xe[3] = 8'h7F;
`ifdef FP_ALIGN_STICKY_EN
    xm[3] = 49'h0_8000_0000_0001; cm[3] = 1;
`else
    xm[3] = 49'h0_8000_0000_0000; cm[3] = 1;
`endif
    va[4] = 32'h7F800000; vb[4] = 32'h3F800000; vs[4] = 0; xs[4] = 0; xe[4] = 8'hFF;
    xm[4] = 49'h0; cm[4] = 0;
    va[5] = 32'h3F800000; vb[5] = 32'h3F000000; vs[5] = 0; xs[5] = 0; xe[5] = 8'h7F;
    xm[5] = 49'h0_C000_0000_0000; cm[5] = 1;
    va[6] = 32'h80000000; vb[6] = 32'h80000000; vs[6] = 0; xs[6] = 1; xe[6] = 8'h00;
    xm[6] = 49'h0; cm[6] = 1;
    va[7] = 32'h80000000; vb[7] = 32'h00000000; vs[7] = 0; xs[7] = 0; xe[7] = 8'h00;
    xm[7] = 49'h0; cm[7] = 1;
    va[8] = 32'h80000000; vb[8] = 32'h00000000; vs[8] = 1; xs[8] = 1; xe[8] = 8'h00;
    xm[8] = 49'h0; cm[8] = 1;
    for (int i = 0; i < 9; i++) begin
      in_a = va[i]; in_b = vb[i]; sub = vs[i]; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early_valid: got %0b want 0", i, valid_out);
      end
      tick();
      checks++;
      if (valid_out !== 1'b1) begin
        errors++; $display("FAIL dir%0d_valid: got %0b want 1", i, valid_out);
      end
      checks++;
      if (sign !== xs[i]) begin
        errors++; $display("FAIL dir%0d_sign: got %0b want %0b", i, sign, xs[i]);
      end
      checks++;
      if (larger_exponent !== xe[i]) begin
        errors++; $display("FAIL dir%0d_exp: got %h want %h", i, larger_exponent, xe[i]);
      end
      if (cm[i]) begin
        checks++;
        if (mantise_temp !== xm[i]) begin
          errors++; $display("FAIL dir%0d_mant: got %h want %h", i, mantise_temp, xm[i]);
        end
      end
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++; $display("FAIL dir%0d_pulse: got %0b want 0", i, valid_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a3 [3];
    logic [31:0] b3 [3];
    logic        s3 [3];
    res_t        e;
    a3[0] = 32'h3F800000; b3[0] = 32'h3F800000; s3[0] = 0;
    a3[1] = 32'h3F800000; b3[1] = 32'h3F800000; s3[1] = 1;
    a3[2] = 32'hC0400000; b3[2] = 32'h3F800000; s3[2] = 0;
    for (int i = 0; i < 3; i++) begin
      in_a = a3[i]; in_b = b3[i]; sub = s3[i]; valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = ref_model(a3[i], b3[i], s3[i]);
      checks++;
      if (valid_out !== 1'b1 || {sign, larger_exponent, mantise_temp} !== e) begin
        errors++;
        $display("FAIL b2b%0d: got v=%0b %h want v=1 %h", i, valid_out,
                 {sign, larger_exponent, mantise_temp}, e);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL b2b_tail: got %0b want 0", valid_out);
    end
  endtask

  task automatic test_reset_midflight();
    res_t e;
    tick();
    for (int i = 0; i < 2; i++) begin
      in_a = 32'hC0400000; in_b = 32'h3F800000; sub = 1'b0; valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({valid_out, sign, larger_exponent, mantise_temp} !== '0) begin
      errors++; $display("FAIL midrst_immediate: got %h want 0",
                         {valid_out, sign, larger_exponent, mantise_temp});
    end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({valid_out, sign, larger_exponent, mantise_temp} !== '0) begin
        errors++; $display("FAIL midrst_quiet%0d: got %h want 0", i,
                           {valid_out, sign, larger_exponent, mantise_temp});
      end
    end
    in_a = 32'h3F800000; in_b = 32'h3F000000; sub = 1'b0; valid_in = 1'b1;
    e = ref_model(in_a, in_b, sub);
    tick();
    valid_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL midrst_early: got %0b want 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || {sign, larger_exponent, mantise_temp} !== e) begin
      errors++; $display("FAIL midrst_resume: got v=%0b %h want v=1 %h", valid_out,
                         {sign, larger_exponent, mantise_temp}, e);
    end
    tick();
  endtask

  task automatic test_random();
    pend_t q[$];
    pend_t p, n;
    res_t  last;
    bit    have_last = 1'b0;
    tick();
    tick();
    n.v = 1'b0;
    n.r = '0;
    q.push_back(n);
    q.push_back(n);
    for (int t = 0; t < 602; t++) begin
      n.v = (t < 600) && ($urandom_range(0, 3) != 0);
      in_a = $urandom;
      in_b = rand_op(in_a);
      sub  = 1'($urandom_range(0, 1));
      valid_in = n.v;
      n.r = ref_model(in_a, in_b, sub);
      q.push_back(n);
      tick();
      p = q.pop_front();
      checks++;
      if (valid_out !== p.v) begin
        errors++; $display("FAIL rand%0d_valid: got %0b want %0b", t, valid_out, p.v);
      end
      if (p.v) begin
        checks++;
        if ({sign, larger_exponent, mantise_temp} !== p.r) begin
          errors++; $display("FAIL rand%0d_data: got %h want %h", t,
                             {sign, larger_exponent, mantise_temp}, p.r);
        end
        last = p.r;
        have_last = 1'b1;
      end else if (have_last) begin
        checks++;
        if ({sign, larger_exponent, mantise_temp} !== last) begin
          errors++; $display("FAIL rand%0d_hold: got %h want %h", t,
                             {sign, larger_exponent, mantise_temp}, last);
        end
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
